// File: rtl/v74x148_latched.sv
// Latched 8-to-3 priority encoder with request capture and acknowledge handshake.
// Latency: a request sampled low at edge n is presented (GS_L=0) after edge n+1;
//   one extra edge when V74X148_GLITCH_FILTER_EN is defined.
// Backpressure: a presented code is frozen in HOLD until ACK; new requests keep
//   accumulating in the pending register meanwhile.
//
// Ports:
//   CLK    - single clock, all state changes on the rising edge
//   RESET  - synchronous active-high reset
//   EI_L   - active-low encoder enable
//   I_L    - active-low request lines, bit 7 highest priority
//   ACK    - active-high acknowledge of the presented code
//   A_L    - active-low encoded index of the presented request (registered)
//   GS_L   - active-low code valid (registered)
//   EO_L   - active-low "enabled, idle and nothing pending" (registered)
//
// Configuration macro: V74X148_GLITCH_FILTER_EN -- when defined, a request line
//   must be sampled low on two consecutive edges before it is captured.
module v74x148_latched (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EI_L,
  input  logic [7:0] I_L,
  input  logic       ACK,
  output logic [2:0] A_L,
  output logic       GS_L,
  output logic       EO_L
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic [2:0] code_q, code_d;
  logic [2:0] a_l_q, a_l_d;
  logic       gs_l_q, gs_l_d;
  logic       eo_l_q, eo_l_d;

  logic [7:0] cap;       // request bits that set pending this edge
  logic [7:0] clr;       // pending bit released by an acknowledge
  logic [2:0] top_idx;   // highest set index of pend_q

`ifdef V74X148_GLITCH_FILTER_EN
  // Remembers which lines were low at the previous edge; a line is captured
  // only when it is low now and was low last edge.
  logic [7:0] filt_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      filt_q <= 8'h00;
    end else begin
      filt_q <= ~I_L;
    end
  end

  assign cap = ~I_L & filt_q;
`else
  assign cap = ~I_L;
`endif

  // Ascending scan so the highest set index wins.
  always_comb begin
    top_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pend_q[i]) begin
        top_idx = 3'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    a_l_d   = a_l_q;
    gs_l_d  = gs_l_q;
    clr     = 8'h00;
    // Based on the values in force before this edge, not the updated ones.
    eo_l_d  = EI_L | (|pend_q) | (state_q != IDLE);

    case (state_q)
      IDLE: begin
        a_l_d  = 3'b111;
        gs_l_d = 1'b1;
        if (!EI_L && (|pend_q)) begin
          code_d  = top_idx;
          a_l_d   = ~top_idx;
          gs_l_d  = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Code and outputs stay frozen regardless of EI_L or new requests.
        if (ACK) begin
          clr     = 8'h01 << code_q;
          a_l_d   = 3'b111;
          gs_l_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Capture is applied after the clear, so a still-active request on the
    // acknowledged line survives and is presented again.
    pend_d = (pend_q & ~clr) | cap;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      pend_q  <= 8'h00;
      code_q  <= 3'd0;
      a_l_q   <= 3'b111;
      gs_l_q  <= 1'b1;
      eo_l_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      a_l_q   <= a_l_d;
      gs_l_q  <= gs_l_d;
      eo_l_q  <= eo_l_d;
    end
  end

  assign A_L  = a_l_q;
  assign GS_L = gs_l_q;
  assign EO_L = eo_l_q;

endmodule

// File: doc/v74x148_latched.md
V74X148_LATCHED -- requirements
Module: v74x148_latched

Interface
REQ-001 SHALL provide port CLK, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL provide port RESET, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL provide port EI_L, input, 1 bit: active-low encoder enable.
REQ-004 SHALL provide port I_L, input, 8 bits: active-low request lines; bit 7 is highest priority.
REQ-005 SHALL provide port ACK, input, 1 bit: active-high consumer acknowledge of the presented code.
REQ-006 SHALL provide port A_L, output, 3 bits: active-low encoded index of the presented request.
REQ-007 SHALL provide port GS_L, output, 1 bit: active-low "code valid" (group select).
REQ-008 SHALL provide port EO_L, output, 1 bit: active-low "enabled and nothing pending".
REQ-009 SHALL make all outputs registered; no combinational path from any input to any output.

Function
REQ-010 SHALL keep an 8-bit pending register P; each cycle P[i] sets when I_L[i]=0 was sampled, regardless of EI_L.
REQ-011 SHALL leave P[i] set until its code is acknowledged; a set bit is not cleared by I_L returning high.
REQ-012 SHALL implement state machine IDLE/HOLD; RESET forces IDLE.
REQ-013 SHALL, in IDLE with EI_L=0 and P nonzero, load the highest set index of P into the code register, drive GS_L=0 and go to HOLD on the next edge.
REQ-014 SHALL drive A_L = bitwise inverse of the held index (index 7 -> 3'b000, index 0 -> 3'b111).
REQ-015 SHALL, in HOLD, freeze A_L and GS_L=0 even if higher-priority requests arrive or EI_L goes high.
REQ-016 SHALL, in HOLD with ACK=1, clear P[held index], drive GS_L=1, A_L=3'b111 and return to IDLE on that edge.
REQ-017 SHALL ignore ACK while in IDLE.
REQ-018 SHALL give capture priority over clear: if I_L[held]=0 in the same cycle as ACK, P[held] remains set and is re-presented from IDLE on the following cycle.
REQ-019 SHALL stay in IDLE with GS_L=1 while EI_L=1; pending bits keep accumulating.
REQ-020 SHALL drive EO_L=0 only when EI_L was 0, P was zero and state was IDLE at the previous edge; otherwise EO_L=1.
REQ-021 SHALL, without the filter, give latency: I_L[i] low at edge n -> P[i] set after edge n -> GS_L=0 after edge n+1 (state IDLE, EI_L=0).
REQ-022 SHALL support back-to-back operation: ACK in HOLD and a nonzero remaining P yields a new code two edges later (HOLD->IDLE->HOLD).

Reset
REQ-023 SHALL, on RESET=1 at a rising edge, set P=0, state=IDLE, A_L=3'b111, GS_L=1, EO_L=1, filter register=0.
REQ-024 SHALL give RESET priority over all inputs, including a mid-HOLD ACK or active requests in the same cycle.
REQ-025 SHALL capture requests only from the first edge after RESET deasserts.

Configuration
REQ-026 SHALL support the macro V74X148_GLITCH_FILTER_EN.
REQ-027 SHALL, when V74X148_GLITCH_FILTER_EN is defined, set P[i] only when I_L[i]=0 on two consecutive edges, adding one cycle of capture latency; a single-cycle low pulse is never captured.
REQ-028 SHALL, when V74X148_GLITCH_FILTER_EN is undefined, capture any single-cycle low sample per REQ-010, with no filter register present.

Verification
REQ-029 SHALL cover: reset, EI_L=0, I_L=8'hFF held -> A_L=3'b111, GS_L=1, EO_L=0 from the second edge.
REQ-030 SHALL cover: one-cycle pulse I_L=8'hDF (bit 5) -> GS_L=0, A_L=3'b010 held until ACK; after ACK, GS_L=1, EO_L=0.
REQ-031 SHALL cover: I_L=8'h7E (bits 7 and 0) for one cycle -> A_L=3'b000; ACK -> next presentation A_L=3'b111 (index 0); ACK -> EO_L=0.
REQ-032 SHALL cover: in HOLD with index 2, raise bit 6; A_L stays 3'b101 until ACK, then A_L=3'b001.
REQ-033 SHALL cover: EI_L=1 with I_L=8'hFB -> GS_L stays 1; EI_L=0 -> A_L=3'b101, GS_L=0 two edges later. Also RESET in HOLD -> all outputs at reset values on the next edge.
REQ-034 SHALL cover: with V74X148_GLITCH_FILTER_EN, a one-cycle low on bit 3 -> no capture; a two-cycle low -> A_L=3'b100.
